// File: rtl/bufg_gt_div_sequencer_pkg.sv
// Shared types and widths for the BUFG_GT divide-ratio sequencer.
// Pulled in by the interface and the sequencer itself.
package bufg_gt_pkg;

  localparam int DIV_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    GATE    = 3'd2,
    LOAD    = 3'd3,
    CLEAR   = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Timed states last N cycles, so the down-counter is loaded with N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/bufg_gt_div_sequencer_if.sv
// Request/status handshake between the clocking CSR block and the sequencer.
// The CSR side drives the request; the sequencer drives the status flags.
interface bufg_gt_div_sequencer_if;

  logic                          req_valid;
  logic [bufg_gt_pkg::DIV_W-1:0] req_div;
  logic                          req_ready;
  logic                          busy;
  logic                          done;

  modport master (output req_valid, req_div, input  req_ready, busy, done);
  modport slave  (input  req_valid, req_div, output req_ready, busy, done);

endinterface

// File: rtl/bufg_gt_div_sequencer.sv
// Glitch-free divide-ratio changer for a BUFG_GT-style buffer:
// gate CE, load DIV, pulse CLR, settle, then re-enable CE.
module bufg_gt_div_sequencer
  import bufg_gt_pkg::*;
#(
  parameter int unsigned      CE_OFF_CYCLES = 4,
  parameter int unsigned      CLR_CYCLES    = 3,
  parameter int unsigned      SETTLE_CYCLES = 4,
  parameter logic [DIV_W-1:0] RESET_DIV     = 3'd0
) (
  input  logic                     clk,
  input  logic                     CLR,
  bufg_gt_div_sequencer_if.slave   req,
  output logic                     BUF_CE,
  output logic                     BUF_CLR,
  output logic [DIV_W-1:0]         BUF_DIV
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DIV_W-1:0]   pending;
  logic               init_seq;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state    <= INIT;
      cnt      <= '0;
      pending  <= RESET_DIV;
      init_seq <= 1'b1;
      BUF_CE   <= 1'b0;
      BUF_CLR  <= 1'b1;
      BUF_DIV  <= RESET_DIV;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case overrides it.
      done_q <= 1'b0;
      case (state)
        INIT: begin
          state    <= CLEAR;
          cnt      <= cnt_load(CLR_CYCLES);
          init_seq <= 1'b1;
        end

        IDLE: begin
          if (req.req_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (req.req_div == BUF_DIV) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              pending  <= req.req_div;
              BUF_CE   <= 1'b0;
              state    <= GATE;
              cnt      <= cnt_load(CE_OFF_CYCLES);
              init_seq <= 1'b0;
            end
          end
        end

        // DIV is updated on the LOAD entry edge so it is visible throughout LOAD.
        GATE: begin
          if (cnt == '0) begin
            state   <= LOAD;
            BUF_DIV <= pending;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        LOAD: begin
          BUF_CLR <= 1'b1;
          state   <= CLEAR;
          cnt     <= cnt_load(CLR_CYCLES);
        end

        CLEAR: begin
          if (cnt == '0) begin
            BUF_CLR <= 1'b0;
            state   <= RELEASE;
            cnt     <= cnt_load(SETTLE_CYCLES);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // The power-up sequence has no requester, so it skips the done pulse.
        RELEASE: begin
          if (cnt == '0) begin
            BUF_CE <= 1'b1;
            if (init_seq) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state    <= INIT;
          cnt      <= '0;
          pending  <= RESET_DIV;
          init_seq <= 1'b1;
          BUF_CE   <= 1'b0;
          BUF_CLR  <= 1'b1;
          BUF_DIV  <= RESET_DIV;
          ready_q  <= 1'b0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bufg_gt_div_sequencer.sv
// Self-checking bench for bufg_gt_div_sequencer: directed scenarios plus random
// traffic, all compared every cycle against a timeline model of the sequence.
module tb_bufg_gt_div_sequencer;
  import bufg_gt_pkg::*;

  localparam int         G = 4;
  localparam int         C = 3;
  localparam int         S = 4;
  localparam int         L = G + 1 + C + S + 1;
  localparam logic [2:0] RST_DIV   = 3'd0;
  localparam logic [7:0] RESET_VEC = 8'b0_1_000_010;
  localparam logic [7:0] IDLE_VEC0 = 8'b1_0_000_100;

  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic       BUF_CE;
  logic       BUF_CLR;
  logic [2:0] BUF_DIV;

  int n_tests = 0;
  int n_fail  = 0;

  bufg_gt_div_sequencer_if req_if();

  bufg_gt_div_sequencer #(
    .CE_OFF_CYCLES(G),
    .CLR_CYCLES   (C),
    .SETTLE_CYCLES(S),
    .RESET_DIV    (RST_DIV)
  ) dut (
    .clk    (clk),
    .CLR    (CLR),
    .req    (req_if),
    .BUF_CE (BUF_CE),
    .BUF_CLR(BUF_CLR),
    .BUF_DIV(BUF_DIV)
  );

  always #5 clk = ~clk;

  // Timeline model: a mode plus the number of cycles elapsed in it.
  typedef enum {M_INIT, M_IDLE, M_CHG, M_NOOP} mmode_t;
  mmode_t     m_mode = M_INIT;
  int         m_k = 0;
  logic [2:0] m_div = RST_DIV;
  logic [2:0] m_new = RST_DIV;
  int         n_exp_done = 0;
  int         n_dut_done = 0;

  always @(posedge clk or posedge CLR) begin
    if (CLR) begin
      m_mode <= M_INIT;
      m_k    <= 0;
      m_div  <= RST_DIV;
    end else begin
      case (m_mode)
        M_INIT: if (m_k == C + S) m_mode <= M_IDLE; else m_k <= m_k + 1;
        M_IDLE: if (req_if.req_valid) begin
          if (req_if.req_div == m_div) begin
            m_mode     <= M_NOOP;
            n_exp_done <= n_exp_done + 1;
          end else begin
            m_mode <= M_CHG;
            m_k    <= 1;
            m_new  <= req_if.req_div;
          end
        end
        M_CHG: if (m_k == L) begin
          m_mode <= M_IDLE;
          m_div  <= m_new;
        end else begin
          m_k <= m_k + 1;
          if (m_k + 1 == L) n_exp_done <= n_exp_done + 1;
        end
        M_NOOP: m_mode <= M_IDLE;
        default: m_mode <= M_INIT;
      endcase
    end
  end

  // Expected {CE, CLR, DIV, ready, busy, done} for the current cycle.
  function automatic logic [7:0] exp_vec();
    logic ce, clr, rdy, bsy, dn;
    logic [2:0] dv;
    ce = 1'b0; clr = 1'b0; rdy = 1'b0; bsy = 1'b1; dn = 1'b0; dv = m_div;
    case (m_mode)
      M_INIT: clr = (m_k <= C);
      M_IDLE: begin ce = 1'b1; rdy = 1'b1; bsy = 1'b0; end
      M_CHG: begin
        ce  = (m_k == L);
        clr = (m_k >= G + 2) && (m_k <= G + 1 + C);
        dv  = (m_k >= G + 1) ? m_new : m_div;
        dn  = (m_k == L);
      end
      M_NOOP: begin ce = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {ce, clr, dv, rdy, bsy, dn};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {BUF_CE, BUF_CLR, BUF_DIV, req_if.req_ready, req_if.busy, req_if.done};
  endfunction

  // Whole-run invariants: CE/CLR exclusivity and DIV stability around CE.
  logic [G-1:0] ce_hist  = '0;
  logic [2:0]   prev_div = RST_DIV;

  always @(negedge clk) begin
    if (CLR) begin
      ce_hist  = '0;
      prev_div = BUF_DIV;
    end else begin
      n_tests++;
      if (BUF_CE && BUF_CLR) begin
        n_fail++;
        $display("FAIL ce_clr_overlap t=%0t: CE=%b CLR=%b, required not both 1", $time, BUF_CE, BUF_CLR);
      end
      n_tests++;
      if ((BUF_CE || (|ce_hist)) && (BUF_DIV !== prev_div)) begin
        n_fail++;
        $display("FAIL div_stable t=%0t: DIV %0d -> %0d with CE history %b/%b", $time, prev_div, BUF_DIV, ce_hist, BUF_CE);
      end
      if (req_if.done === 1'b1) n_dut_done++;
      ce_hist  = {ce_hist[G-2:0], BUF_CE};
      prev_div = BUF_DIV;
    end
  end

  task automatic test_reset();
    CLR = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_div   = 3'd0;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== RESET_VEC) begin
        n_fail++;
        $display("FAIL reset_vals: got %b want %b", obs_vec(), RESET_VEC);
      end
    end
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL init_seq cyc %0d: got %b want %b", i + 1, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (obs_vec() !== IDLE_VEC0) begin
      n_fail++;
      $display("FAIL init_idle: got %b want %b", obs_vec(), IDLE_VEC0);
    end
  endtask

  task automatic test_change();
    req_if.req_valid = 1'b1;
    req_if.req_div   = 3'd3;
    for (int i = 1; i <= L + 1; i++) begin
      @(negedge clk);
      req_if.req_valid = 1'b0;
      req_if.req_div   = 3'($urandom_range(0, 7));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL change_0_3 T+%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (BUF_DIV !== 3'd3) begin
      n_fail++;
      $display("FAIL change_final_div: got %0d want 3", BUF_DIV);
    end
  endtask

  task automatic test_noop();
    req_if.req_valid = 1'b1;
    req_if.req_div   = 3'd3;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      req_if.req_valid = 1'b0;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL noop T+%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_tests++;
      if (BUF_CE !== 1'b1 || BUF_CLR !== 1'b0 || req_if.done !== (i == 1)) begin
        n_fail++;
        $display("FAIL noop_ce T+%0d: CE=%b CLR=%b done=%b, required CE=1 CLR=0 done=%b", i, BUF_CE, BUF_CLR, req_if.done, i == 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] last;
    logic [2:0] chg[$];
    logic       drop;
    logic       finished;
    last = BUF_DIV;
    drop = 1'b0;
    finished = 1'b0;
    req_if.req_valid = 1'b1;
    req_if.req_div   = 3'd5;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (BUF_DIV !== last) begin
        chg.push_back(BUF_DIV);
        last = BUF_DIV;
      end
      if (i == 2) req_if.req_div = 3'd7;
      if (drop) begin
        req_if.req_valid = 1'b0;
        finished = 1'b1;
      end
      if (i > 2 && req_if.req_ready && req_if.req_valid) drop = 1'b1;
    end
    req_if.req_valid = 1'b0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL b2b_timeout: second request never accepted within 45 cycles");
    end
    n_tests++;
    if (chg.size() != 2 || chg[0] !== 3'd5 || chg[1] !== 3'd7) begin
      n_fail++;
      $display("FAIL b2b_div_order: got %0d changes %p, required 5 then 7", chg.size(), chg);
    end
  endtask

  task automatic test_clr_mid();
    req_if.req_valid = 1'b1;
    req_if.req_div   = 3'd6;
    for (int i = 1; i <= G + 3; i++) begin
      @(negedge clk);
      req_if.req_valid = 1'b0;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clr_mid_pre T+%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (BUF_CLR !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_mid_in_clear: CLR=%b, required 1", BUF_CLR);
    end
    #2 CLR = 1'b1;
    #1;
    n_tests++;
    if (obs_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL clr_mid_async: got %b want %b", obs_vec(), RESET_VEC);
    end
    repeat (2) @(negedge clk);
    CLR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec() || BUF_DIV === 3'd6) begin
        n_fail++;
        $display("FAIL clr_mid_post cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int clr_hold;
    clr_hold = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (clr_hold > 0) begin
        clr_hold--;
        if (clr_hold == 0) CLR = 1'b0;
      end else if ($urandom_range(0, 119) == 0) begin
        clr_hold = 2;
        #2 CLR = 1'b1;
      end
      req_if.req_valid = ($urandom_range(0, 2) == 0);
      req_if.req_div   = ($urandom_range(0, 3) == 0) ? m_div : 3'($urandom_range(0, 7));
    end
    CLR = 1'b0;
    req_if.req_valid = 1'b0;
    for (int i = 0; i < 40 && req_if.req_ready !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (req_if.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL random_drain: req_ready=%b after 40 cycles, required 1", req_if.req_ready);
    end
  endtask

  task automatic test_done_count();
    n_tests++;
    if (n_dut_done != n_exp_done) begin
      n_fail++;
      $display("FAIL done_count: got %0d pulses want %0d", n_dut_done, n_exp_done);
    end
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_div   = 3'd0;
    test_reset();
    test_change();
    test_noop();
    test_back_to_back();
    test_clr_mid();
    test_random();
    test_done_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bufg_gt_div_sequencer.md
Name: bufg_gt_div_sequencer

Overview:
- Control-side sequencer for a BUFG_GT-style divided clock buffer.
- Owns the buffer's CE, CLR and DIV inputs. Performs glitch-free divide-ratio changes: gate CE, load DIV, pulse CLR, settle, re-enable CE.
- Runs on a free-running system clock that is independent of the buffered clock. It sits between the clocking CSR block and the transceiver clock buffer.

Parameters:
- CE_OFF_CYCLES, 4: cycles CE is held low before DIV changes. Covers the buffer's 2-stage CE synchroniser plus the falling-edge mask. Range 1..255.
- CLR_CYCLES, 3: cycles BUF_CLR is held high. Range 1..255.
- SETTLE_CYCLES, 4: cycles between CLR deassert and CE reassert. Range 1..255.
- RESET_DIV, 3'd0: BUF_DIV value driven during and after reset.

Ports:
- clk  in  1  free-running system clock; all logic on its posedge.
- CLR  in  1  reset, asynchronous, active-high.
- req_valid  in  1  divide-change request.
- req_div  in  3  requested DIV code; buffer divides by code+1.
- req_ready  out  1  high only in IDLE.
- BUF_CE  out  1  to buffer CE.
- BUF_CLR  out  1  to buffer CLR.
- BUF_DIV  out  3  to buffer DIV.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes (including the no-op case).

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- While CLR is high: state=INIT, BUF_CE=0, BUF_CLR=1, BUF_DIV=RESET_DIV, req_ready=0, busy=1, done=0, counter=0.
- A single 8-bit down-counter serves every timed state. It is loaded with N-1 on state entry, so each timed state lasts exactly N cycles.
- States and transitions:
  - INIT: entered from reset. On the first clk after CLR falls, go to CLEAR with counter=CLR_CYCLES-1. BUF_CLR stays 1 throughout.
  - IDLE: BUF_CE=1, BUF_CLR=0, req_ready=1. On req_valid&req_ready:
    - If req_div==BUF_DIV: go to DONE. CE is never dropped.
    - Otherwise: latch req_div into a pending register, go to GATE, and set BUF_CE=0 on the same edge.
  - GATE: BUF_CE=0 for CE_OFF_CYCLES cycles, then LOAD.
  - LOAD: one cycle. BUF_DIV<=pending; BUF_CLR<=1 on the exit edge; go to CLEAR.
  - CLEAR: BUF_CLR=1 for CLR_CYCLES cycles, then RELEASE with BUF_CLR<=0.
  - RELEASE: BUF_CLR=0, BUF_CE=0 for SETTLE_CYCLES cycles. Then BUF_CE<=1 and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, accept edge to done pulse: CE_OFF_CYCLES+1+CLR_CYCLES+SETTLE_CYCLES+1 cycles. With defaults this is 13. The no-op case takes 1 cycle.
- BUF_DIV changes only in LOAD (or reset), and only while BUF_CE has been 0 for at least CE_OFF_CYCLES cycles.
- BUF_CE and BUF_CLR are never both 1.
- Requests outside IDLE are not accepted. req_valid may stay high; it is accepted on the first IDLE cycle.
- req_div is sampled only on the accept edge. Later changes have no effect.
- If CLR asserts mid-sequence, the sequencer returns immediately to the reset values. The pending DIV is discarded and BUF_DIV=RESET_DIV.
- The state encoding has no illegal states; any unreachable encoding decodes to INIT.

Decomposition:
- Shared package bufg_gt_pkg:
  - state enum (INIT, IDLE, GATE, LOAD, CLEAR, RELEASE, DONE);
  - DIV code width constant (3);
  - counter width constant (8).
- Single flat module. No sub-module is needed; the down-counter is inline.

Test Plan:
- Reset release, defaults: CLR 1->0 -> BUF_CLR stays 1 for 3 clk, then 4 clk with CE=0, then BUF_CE=1, req_ready=1. BUF_DIV=0 throughout.
- Change 0->3 from IDLE: req_div=3 accepted at cycle T -> BUF_CE=0 from T+1 and BUF_DIV=3 at T+5. BUF_CLR is high T+6..T+8, BUF_CE=1 at T+13, done pulses at T+13 only.
- No-op request: req_div equals the current BUF_DIV (3) -> BUF_CE never drops, BUF_CLR stays 0, done pulses at the next cycle.
- Back-to-back: req_valid held high with req_div=5, then 7 presented while busy -> only 5 is applied. 7 is accepted at the first IDLE cycle; BUF_DIV goes 5 then 7, and each change is preceded by ≥4 cycles of CE=0.
- CLR asserted during CLEAR of a change to 6 -> outputs immediately return to CE=0, CLR=1, DIV=0. After release, the INIT sequence runs and DIV=6 never appears.
- Assertions for the whole run:
  - never CE&CLR;
  - DIV is stable whenever BUF_CE=1 or BUF_CE was 1 in the previous 4 cycles;
  - done is exactly one pulse per accepted request.
